// File: rtl/tone_arbiter.sv
// tone_arbiter
//   Shares one pwm_generator tone datapath between N_REQ requesters using
//   fixed priority (index 0 highest), with optional preemption. The granted
//   note's frequency and duration are latched at grant time and driven to the
//   generator. The generator's completion is returned to the owner as a done
//   pulse, or as an abort pulse if the note was cut short. A silent guard gap
//   follows every note.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   req        in   [N_REQ]        level request per requester, held until done/abort
//   req_freq   in   [N_REQ*FREQ_W] packed; slice i = requester i frequency (0 = rest)
//   req_dur    in   [N_REQ*DUR_W]  packed; slice i = requester i duration (ms)
//   grant      out  [N_REQ]        one-hot owner, 0 when idle
//   done       out  [N_REQ]        1-cycle pulse: owner's note completed
//   abort      out  [N_REQ]        1-cycle pulse: owner's note cut short
//   pwm_freq   out  [FREQ_W]       to pwm_generator.freq
//   pwm_dur    out  [DUR_W]        to pwm_generator.duration
//   pwm_enable out                 to pwm_generator.enable
//   pwm_done   in                  from pwm_generator.done (honoured only while playing)
//   busy       out                 arbiter not idle
module tone_arbiter #(
  parameter int N_REQ      = 3,
  parameter int FREQ_W     = 32,
  parameter int DUR_W      = 32,
  parameter int PREEMPT    = 1,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*FREQ_W-1:0] req_freq,
  input  logic [N_REQ*DUR_W-1:0]  req_dur,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        abort,
  output logic [FREQ_W-1:0]       pwm_freq,
  output logic [DUR_W-1:0]        pwm_dur,
  output logic                    pwm_enable,
  input  logic                    pwm_done,
  output logic                    busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam int CNT_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  // Last count value of the gap; a zero-length gap still spends one cycle in GAP.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  logic [1:0]        r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [N_REQ-1:0]  r_done;
  logic [N_REQ-1:0]  r_abort;
  logic [FREQ_W-1:0] r_freq;
  logic [DUR_W-1:0]  r_dur;
  logic              r_en;
  logic              r_busy;
  logic [CNT_W-1:0]  r_gap_cnt;

  logic [N_REQ-1:0]  w_sel_oh;
  logic [FREQ_W-1:0] w_sel_freq;
  logic [DUR_W-1:0]  w_sel_dur;
  logic              w_owner_req;
  logic              w_higher_req;
  logic              w_preempt;

  // Lowest-index requester wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_sel_oh   = '0;
    w_sel_freq = '0;
    w_sel_dur  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_sel_freq  = req_freq[i*FREQ_W +: FREQ_W];
        w_sel_dur   = req_dur[i*DUR_W +: DUR_W];
      end
    end
  end

  assign w_owner_req  = |(req & r_grant);
  // grant is one-hot while playing, so grant-1 masks exactly the higher-priority indices.
  assign w_higher_req = |(req & (r_grant - N_REQ'(1)));
  assign w_preempt    = (PREEMPT != 0) && w_higher_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_done    <= '0;
      r_abort   <= '0;
      r_freq    <= '0;
      r_dur     <= '0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_done  <= '0;
      r_abort <= '0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_freq  <= w_sel_freq;
            r_dur   <= w_sel_dur;
            r_grant <= w_sel_oh;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        // One settle cycle with enable low so the generator sees the new note first.
        LOAD: begin
          if (r_dur == '0) begin
            r_done    <= r_grant;
            r_grant   <= '0;
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end else begin
            r_en    <= 1'b1;
            r_state <= PLAY;
          end
        end
        // Completion outranks a dropped request, which outranks preemption.
        PLAY: begin
          if (pwm_done) begin
            r_done    <= r_grant;
            r_grant   <= '0;
            r_en      <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end else if (!w_owner_req || w_preempt) begin
            r_abort   <= r_grant;
            r_grant   <= '0;
            r_en      <= 1'b0;
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign abort      = r_abort;
  assign pwm_freq   = r_freq;
  assign pwm_dur    = r_dur;
  assign pwm_enable = r_en;
  assign busy       = r_busy;

endmodule
